// File: rtl/tt_uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and sizing.
package tt_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int DATA_BITS = 8;
  // Wide enough for the largest legal CLKS_PER_BIT (65535)
  localparam int CNT_W     = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; resets to 1 (idle line).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-byte valid/ready output buffer,
// framing-error and overrun pulses.
//   state | meaning
//   IDLE  | waiting for a 1->0 transition on the synchronised line
//   START | timing to the middle of the start bit to reject glitches
//   DATA  | sampling 8 data bits LSB first, one per bit period
//   STOP  | sampling the stop bit, then delivering or discarding the byte
module uart_rx
  import tt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t          state, state_nxt;
  logic                 rx_s, rx_prev;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick, shift_en, load, drop, ferr;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    shift_en  = 1'b0;
    load      = 1'b0;
    drop      = 1'b0;
    ferr      = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_TC) begin
          tick      = 1'b1;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_TC) begin
          tick     = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'(DATA_BITS - 1)) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_TC) begin
          tick      = 1'b1;
          state_nxt = IDLE;
          // A full buffer can still take the byte if it is being drained this edge
          if (rx_s) begin
            if (!valid || ready) load = 1'b1;
            else                 drop = 1'b1;
          end else begin
            ferr = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev   <= 1'b1;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_prev   <= rx_s;
      frame_err <= ferr;
      overrun   <= drop;
      if (state_nxt != state || state == IDLE) begin
        cnt     <= '0;
        bit_idx <= '0;
      end else if (tick) begin
        cnt     <= '0;
        bit_idx <= bit_idx + 3'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (load) begin
        data  <= shreg;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT=8: directed corner cases plus a frame table,
// with accepted bytes checked against a queue of expected bytes.
module tb_uart_rx;
  import tt_uart_pkg::*;

  localparam int C   = 8;
  // 2 synchroniser edges + 1 detect edge + C/2 + 9*C
  localparam int LAT = 3 + C / 2 + 9 * C;

  logic       clk = 1'b0;
  logic       rst, rx, ready;
  logic [7:0] data;
  logic       valid, frame_err, overrun;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         rise_cyc = -1;
  int         frame_start = 0;
  logic       valid_q = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         ferr_inc;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit pulse_rdy);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    frame_start = cyc;
    for (int i = 0; i < 10 * C; i++) begin
      rx = bits[i/C];
      if (pulse_rdy) ready = (i == LAT - 1);
      step(1);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (valid && !valid_q) rise_cyc = cyc;
    valid_q = valid;
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL accept_unexpected: got data %0h, required no pending byte", data);
      end else begin
        check("accept_data", {24'h0, data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, o0;
    vecs[0] = '{8'hA5, 1'b1, 0};
    vecs[1] = '{8'h00, 1'b1, 0};
    vecs[2] = '{8'hFF, 1'b1, 0};
    vecs[3] = '{8'h81, 1'b0, 1};
    vecs[4] = '{8'h7E, 1'b1, 0};
    vecs[5] = '{8'h3C, 1'b0, 1};
    vecs[6] = '{8'h01, 1'b1, 0};

    rst = 1'b1; rx = 1'b1; ready = 1'b0;
    step(3);
    check("reset_data", {24'h0, data}, 32'h0);
    check("reset_valid", {31'h0, valid}, 32'h0);
    check("reset_ferr", {31'h0, frame_err}, 32'h0);
    check("reset_ovr", {31'h0, overrun}, 32'h0);
    check("reset_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    step(2);

    // Good frame, latency and hold-until-accept
    rise_cyc = -1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_latency", 32'(rise_cyc - frame_start), 32'(LAT));
    step(20);
    check("a5_hold_valid", {31'h0, valid}, 32'h1);
    check("a5_hold_data", {24'h0, data}, 32'hA5);
    ready = 1'b1; step(1); ready = 1'b0;
    check("a5_cleared", {31'h0, valid}, 32'h0);

    // Glitch shorter than half a bit
    f0 = ferr_cnt;
    rx = 1'b0; step(3); rx = 1'b1; step(20);
    check("glitch_valid", {31'h0, valid}, 32'h0);
    check("glitch_ferr", 32'(ferr_cnt - f0), 32'h0);
    check("glitch_state", 32'(dut.state), 32'(IDLE));
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    check("glitch_next_valid", {31'h0, valid}, 32'h1);
    ready = 1'b1; step(2); ready = 1'b0;

    // Framing error, then line held low (break) must not retrigger
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    step(2);
    check("ferr_pulse", 32'(ferr_cnt - f0), 32'h1);
    check("ferr_valid", {31'h0, valid}, 32'h0);
    step(40);
    check("break_no_retrigger", 32'(ferr_cnt - f0), 32'h1);
    check("break_state", 32'(dut.state), 32'(IDLE));
    rx = 1'b1; step(5);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    ready = 1'b1; step(2); ready = 1'b0;

    // Overrun: second byte dropped
    o0 = ovr_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    step(2);
    check("ovr_data", {24'h0, data}, 32'h11);
    check("ovr_valid", {31'h0, valid}, 32'h1);
    check("ovr_pulses", 32'(ovr_cnt - o0), 32'h1);
    ready = 1'b1; step(1); ready = 1'b0;
    check("ovr_cleared", {31'h0, valid}, 32'h0);

    // Accept of 0x00 on the same edge that loads 0xFF
    o0 = ovr_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b1);
    step(1);
    check("sim_valid", {31'h0, valid}, 32'h1);
    check("sim_data", {24'h0, data}, 32'hFF);
    check("sim_no_ovr", 32'(ovr_cnt - o0), 32'h0);
    check("sim_pending", 32'(exp_q.size()), 32'h1);
    ready = 1'b1; step(1); ready = 1'b0;
    check("sim_cleared", {31'h0, valid}, 32'h0);

    // Reset after the 4th data bit
    f0 = ferr_cnt; o0 = ovr_cnt;
    for (int i = 0; i < 5 * C; i++) begin
      rx = (i < C) ? 1'b0 : 1'b1;
      step(1);
    end
    rst = 1'b1;
    step(2);
    check("midrst_valid", {31'h0, valid}, 32'h0);
    check("midrst_data", {24'h0, data}, 32'h0);
    check("midrst_ferr", {31'h0, frame_err}, 32'h0);
    check("midrst_ovr", {31'h0, overrun}, 32'h0);
    check("midrst_state", 32'(dut.state), 32'(IDLE));
    rx = 1'b1; step(2);
    rst = 1'b0; step(3);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    step(1);
    check("midrst_recover_valid", {31'h0, valid}, 32'h1);
    check("midrst_no_pulses", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'h0);
    ready = 1'b1; step(1); ready = 1'b0;

    // Frame table with the consumer always ready
    ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rx = 1'b1; step(4);
      f0 = ferr_cnt;
      if (vecs[i].stop) exp_q.push_back(vecs[i].b);
      send_frame(vecs[i].b, vecs[i].stop, 1'b0);
      step(2);
      check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0), 32'(vecs[i].ferr_inc));
    end
    ready = 1'b0;
    rx = 1'b1; step(4);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 87, meaning clock cycles per serial bit (10 MHz / 115200); legal range 4..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port rx, input, 1 bit: asynchronous serial line from ui_in[0], 8N1, LSB first, idle high.
REQ-005 The block SHALL have port data, output, 8 bits: the received byte.
REQ-006 The block SHALL have port valid, output, 1 bit: data holds an unconsumed byte.
REQ-007 The block SHALL have port ready, input, 1 bit: the consumer accepts data when valid and ready are both high on a clock edge.
REQ-008 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a stop bit is sampled low.
REQ-009 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a good byte is dropped because the output buffer is full.

Function
REQ-010 rx SHALL pass through a 2-flop synchroniser; rx_s is the output of the second flop, and all logic below uses rx_s only.
REQ-011 The FSM SHALL have states IDLE, START, DATA and STOP; a bit-cycle counter and a 3-bit bit index are cleared on every state entry.
REQ-012 IDLE SHALL move to START only on a falling edge of rx_s (previous 1, current 0); a line held low after a break SHALL NOT retrigger.
REQ-013 START SHALL sample rx_s after CLKS_PER_BIT/2 cycles (integer division); if the sample is 0 it SHALL go to DATA, else return to IDLE (glitch rejected, no outputs).
REQ-014 DATA SHALL sample rx_s every CLKS_PER_BIT cycles, shifting samples LSB first; after the 8th sample it SHALL go to STOP.
REQ-015 STOP SHALL sample rx_s after CLKS_PER_BIT cycles and then always return to IDLE.
REQ-016 On a stop sample of 1 with the buffer empty, or with the buffer full and ready high in that cycle, data and valid SHALL be loaded on that edge.
REQ-017 On a stop sample of 1 with the buffer full and ready low, overrun SHALL pulse for one cycle; the new byte is dropped and data is unchanged.
REQ-018 On a stop sample of 0, frame_err SHALL pulse for one cycle and the byte SHALL be discarded.
REQ-019 Once valid is high, data SHALL remain stable until accepted; acceptance without a simultaneous load SHALL clear valid on that edge.
REQ-020 valid SHALL rise exactly CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the edge on which IDLE first sees rx_s low.
REQ-021 Reception SHALL be independent of ready; the FSM never stalls.

Reset
REQ-022 While rst is high, the FSM SHALL be in IDLE, counters and the shift register 0, synchroniser flops 1, data 0x00, and valid, frame_err and overrun 0.
REQ-023 A reset asserted mid-frame SHALL abort the frame with no outputs; the next complete frame after release SHALL be received correctly.

Structure
REQ-024 The state enum, DATA_BITS (8) and the counter width SHALL live in a shared package tt_uart_pkg, for reuse by a future uart_tx.
REQ-025 The synchroniser SHALL be a separate sub-module, sync_2ff (reset value 1); all other logic SHALL be in uart_rx.

Verification (bench uses CLKS_PER_BIT=8)
REQ-026 Good frame: send 0xA5 with ready low -> valid rises 76 cycles after rx_s first low, data=0xA5 held until ready=1, then valid=0.
REQ-027 Glitch: drive rx low for 3 cycles, then high -> no valid, no frame_err, FSM back in IDLE; a following 0x3C is received correctly.
REQ-028 Framing error: send 0x3C with the stop bit low -> single frame_err pulse, valid stays 0; no new start until rx returns high, then falls again.
REQ-029 Overrun: send 0x11 then 0x22 with ready low -> data=0x11, exactly one overrun pulse; after an accept, valid=0.
REQ-030 Simultaneous load and accept: send 0x00 then 0xFF back-to-back, with ready pulsed on the 0xFF load edge -> 0x00 consumed, valid stays 1 with data=0xFF, no overrun.
REQ-031 Reset mid-frame: assert rst after the 4th data bit -> all outputs at reset values; after release, 0x5A is received correctly.
